// File: rtl/mux4_rr_arbiter_8bit_if.sv
// mux4_rr_arbiter_8bit_if: requester/downstream bundle of the round-robin 4:1 mux arbiter
interface mux4_rr_arbiter_8bit_if;
  logic [3:0] req;
  logic [7:0] i0, i1, i2, i3;
  logic ready;
  logic [3:0] gnt;
  logic sel1, sel0;
  logic [7:0] f;
  logic valid;
  modport master (output req, i0, i1, i2, i3, ready, input gnt, sel1, sel0, f, valid);
  modport slave (input req, i0, i1, i2, i3, ready, output gnt, sel1, sel0, f, valid);
endinterface

// File: rtl/mux4_rr_arbiter_8bit.sv
// mux4_rr_arbiter_8bit: round-robin grant of a shared 8-bit 4:1 mux with burst-bounded tenures
module mux4_rr_arbiter_8bit #(
  parameter int BURST = 4,
  parameter int CNTW = 4
) (
  input logic clk,
  input logic rst,
  mux4_rr_arbiter_8bit_if.slave b
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [3:0] gnt;
  logic [1:0] sel, ptr, win;
  logic [CNTW-1:0] cnt;
  logic [7:0] data;
  logic valid, beat, rel;
  // first requester at or after ptr, scanning with 2-bit wrap
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (b.req[ptr + 2'(k)]) win = ptr + 2'(k);
  end
  always_comb begin
    data = sel == 2'd0 ? b.i0 : sel == 2'd1 ? b.i1 : sel == 2'd2 ? b.i2 : b.i3;
    valid = state == GRANT && b.req[sel];
    beat = valid && b.ready;
    rel = !b.req[sel] || (beat && cnt == CNTW'(BURST - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (|b.req) begin
        state <= GRANT;
        gnt <= 4'b0001 << win;
        sel <= win;
        cnt <= '0;
      end
    end else if (rel) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= sel + 2'd1;
      cnt <= '0;
    end else if (beat) begin
      cnt <= cnt + 1'b1;
    end
  end
  assign b.gnt = gnt;
  assign b.sel1 = sel[1];
  assign b.sel0 = sel[0];
  assign b.valid = valid;
  assign b.f = state == GRANT ? data : 8'h00;
endmodule

// File: tb/tb_mux4_rr_arbiter_8bit.sv
// tb_mux4_rr_arbiter_8bit: table vectors, corner sequences and random traffic against a tenure-level model
module tb_mux4_rr_arbiter_8bit;
  localparam int BURST = 4;
  logic clk = 0;
  logic rst;
  mux4_rr_arbiter_8bit_if b();
  mux4_rr_arbiter_8bit #(.BURST(BURST), .CNTW(4)) dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  logic [7:0] d [4];
  int m_owner = -1, m_ptr = 0, m_beats = 0, m_sel = 0;
  typedef struct {
    logic r;
    logic [3:0] rq;
    logic rd;
    logic [14:0] e;
  } vec_t;
  vec_t tv [13];
  function automatic logic [14:0] model_out();
    logic [3:0] g;
    logic v;
    logic [7:0] fv;
    g = m_owner >= 0 ? 4'(1 << m_owner) : 4'h0;
    v = m_owner >= 0 && b.req[m_owner];
    fv = m_owner >= 0 ? d[m_owner] : 8'h00;
    return {g, 2'(m_sel), v, fv};
  endfunction
  task automatic model_update();
    logic beat;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      for (int off = 0; off < 4; off++)
        if (m_owner < 0 && b.req[(m_ptr + off) % 4]) m_owner = (m_ptr + off) % 4;
      if (m_owner >= 0) begin m_sel = m_owner; m_beats = 0; end
    end else begin
      beat = b.req[m_owner] && b.ready;
      if (beat) m_beats++;
      if (!b.req[m_owner] || (beat && m_beats == BURST)) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1; m_beats = 0;
      end
    end
  endtask
  task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got gnt=%b sel=%b valid=%b f=%h, want gnt=%b sel=%b valid=%b f=%h",
                  nm, got[14:11], got[10:9], got[8], got[7:0], exp[14:11], exp[10:9], exp[8], exp[7:0]);
  endtask
  task automatic chk_gnt(input string nm, input logic [3:0] exp);
    total++;
    if (b.gnt === exp) passed++;
    else $display("FAIL %s: gnt got %b want %b", nm, b.gnt, exp);
  endtask
  // mode 0: no check, 1: against model, 2: against exp
  task automatic step(input logic r, input logic [3:0] rq, input logic rd, input string nm,
                      input int mode, input logic [14:0] exp);
    @(negedge clk);
    rst = r; b.req = rq; b.ready = rd;
    b.i0 = d[0]; b.i1 = d[1]; b.i2 = d[2]; b.i3 = d[3];
    #1;
    if (mode == 1) chk(nm, {b.gnt, b.sel1, b.sel0, b.valid, b.f}, model_out());
    if (mode == 2) chk(nm, {b.gnt, b.sel1, b.sel0, b.valid, b.f}, exp);
    @(posedge clk);
    model_update();
  endtask
  initial begin
    logic [3:0] rq;
    logic rd [6];
    rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'h1D; d[3] = 8'hC3;
    tv[0]  = '{1'b1, 4'hF, 1'b1, {4'b0000, 2'b00, 1'b0, 8'h00}};
    tv[1]  = '{1'b0, 4'hF, 1'b1, {4'b0000, 2'b00, 1'b0, 8'h00}};
    tv[2]  = '{1'b0, 4'hF, 1'b1, {4'b0001, 2'b00, 1'b1, 8'hA0}};
    tv[3]  = '{1'b1, 4'h4, 1'b1, {4'b0001, 2'b00, 1'b0, 8'hA0}};
    tv[4]  = '{1'b0, 4'h4, 1'b1, {4'b0000, 2'b00, 1'b0, 8'h00}};
    for (int k = 5; k <= 8; k++) tv[k] = '{1'b0, 4'h4, 1'b1, {4'b0100, 2'b10, 1'b1, 8'h1D}};
    tv[9]  = '{1'b0, 4'h4, 1'b1, {4'b0000, 2'b10, 1'b0, 8'h00}};
    tv[10] = '{1'b0, 4'h4, 1'b1, {4'b0100, 2'b10, 1'b1, 8'h1D}};
    tv[11] = '{1'b0, 4'h0, 1'b1, {4'b0100, 2'b10, 1'b0, 8'h1D}};
    tv[12] = '{1'b0, 4'h0, 1'b1, {4'b0000, 2'b10, 1'b0, 8'h00}};
    step(1, 4'hF, 1, "init", 0, '0);
    foreach (tv[k]) step(tv[k].r, tv[k].rq, tv[k].rd, $sformatf("vec%0d", k), 2, tv[k].e);
    step(1, 4'h0, 1, "rr_rst", 1, '0);
    for (int c = 0; c < 25; c++) begin
      step(0, 4'hF, 1, "rr", 1, '0);
      #1;
      if (c % 5 == 0) chk_gnt($sformatf("rr_order%0d", c / 5), 4'(1 << ((c / 5) % 4)));
      if (c % 5 == 4) chk_gnt($sformatf("rr_idle%0d", c / 5), 4'h0);
    end
    step(1, 4'h0, 1, "bp_rst", 1, '0);
    step(0, 4'h2, 1, "bp_req", 1, '0);
    for (int k = 0; k < 6; k++) begin
      step(0, 4'h2, rd[k], "bp", 1, '0);
      #1;
      if (k == 4) chk_gnt("bp_hold", 4'b0010);
      if (k == 5) chk_gnt("bp_release", 4'h0);
    end
    step(1, 4'h0, 1, "ed_rst", 1, '0);
    step(0, 4'h8, 1, "ed_req", 1, '0);
    step(0, 4'h8, 1, "ed_beat", 1, '0);
    step(0, 4'h8, 1, "ed_beat", 1, '0);
    step(0, 4'h3, 1, "ed_drop", 1, '0);
    step(0, 4'h3, 1, "ed_regrant", 1, '0);
    #1 chk_gnt("ed_wrap_to0", 4'b0001);
    step(1, 4'h0, 1, "rm_rst", 1, '0);
    step(0, 4'h4, 1, "rm_req", 1, '0);
    step(0, 4'h4, 1, "rm_beat1", 1, '0);
    step(1, 4'h4, 1, "rm_beat2", 1, '0);
    #1 chk_gnt("rm_cleared", 4'h0);
    step(0, 4'h6, 1, "rm_pend", 1, '0);
    #1 chk_gnt("rm_grant1", 4'b0010);
    rq = 4'h0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step($urandom_range(0, 49) == 0, rq, $urandom_range(0, 3) != 0, "rand", 1, '0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
